// File: rtl/arb_req_client.sv
// Requester-side front end for the round-robin arbiter: per-client FIFOs, req/grant, 2-entry output buffer.
// Optional ARB_REQ_CHK_EN adds a sticky err output and drops illegal grant beats.
module arb_req_client #(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic [N*W-1:0]       in_data,
  output logic [N-1:0]         req,
  input  logic [N-1:0]         grant,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         out_data,
  output logic [$clog2(N)-1:0] out_id
`ifdef ARB_REQ_CHK_EN
  ,
  output logic                 err
`endif
);

  localparam int IW = $clog2(N);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [W-1:0]  mem [N][DEPTH];
  logic [AW-1:0] wp [N];
  logic [AW-1:0] rp [N];
  logic [CW-1:0] cnt [N];

  logic [N-1:0]  push;
  logic [N-1:0]  pop;
  logic [N-1:0]  nonempty;
  logic          g;
  logic          p;
  logic          ovf;
  logic          req_en;
  logic [2:0]    need;
  logic          ob_push;
  logic [W-1:0]  sel_data;
  logic [IW-1:0] sel_id;

  logic [1:0]    ob_cnt;
  logic [W-1:0]  hd_data;
  logic [IW-1:0] hd_id;
  logic [W-1:0]  tl_data;
  logic [IW-1:0] tl_id;

`ifdef ARB_REQ_CHK_EN
  logic          bad;
`endif

  assign out_valid = (ob_cnt != 2'd0);
  assign out_data  = hd_data;
  assign out_id    = hd_id;

  // Client-side status, request vector and output credit
  always_comb begin
    g    = |grant;
    p    = out_valid & out_ready;
    ovf  = g & (ob_cnt == 2'd2) & ~p;
    need = 3'(ob_cnt) + 3'(g) - 3'(p);
    req_en = (need <= 3'd1);
    in_ready = '0;
    push     = '0;
    nonempty = '0;
    req      = '0;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = (cnt[i] != FULL);
      push[i]     = in_valid[i] & in_ready[i];
      nonempty[i] = (cnt[i] != '0);
      req[i]      = (cnt[i] > CW'(grant[i])) & req_en;
    end
  end

  // Grant qualification: which FIFO pops and what goes to the output buffer
  always_comb begin
`ifdef ARB_REQ_CHK_EN
    bad = ((grant & (grant - 1'b1)) != '0)
        | (|(grant & ~nonempty))
        | ovf;
    pop = grant & {N{~bad}};
`else
    pop = grant & nonempty & {N{~ovf}};
`endif
    ob_push  = |pop;
    sel_data = '0;
    sel_id   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pop[i]) begin
        sel_data = mem[i][rp[i]];
        sel_id   = IW'(i);
      end
    end
  end

  // Client FIFO storage writes
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (push[i]) mem[i][wp[i]] <= in_data[i*W +: W];
    end
  end

  // Client FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        wp[i]  <= '0;
        rp[i]  <= '0;
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (push[i]) wp[i] <= wp[i] + AW'(1);
        if (pop[i])  rp[i] <= rp[i] + AW'(1);
        if (push[i] & ~pop[i])
          cnt[i] <= cnt[i] + CW'(1);
        else if (~push[i] & pop[i])
          cnt[i] <= cnt[i] - CW'(1);
      end
    end
  end

  // Two-entry output buffer, head register drives the outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ob_cnt  <= '0;
      hd_data <= '0;
      hd_id   <= '0;
      tl_data <= '0;
      tl_id   <= '0;
    end else begin
      case ({ob_push, p})
        2'b10: begin
          if (ob_cnt == 2'd0) begin
            hd_data <= sel_data;
            hd_id   <= sel_id;
          end else begin
            tl_data <= sel_data;
            tl_id   <= sel_id;
          end
          ob_cnt <= ob_cnt + 2'd1;
        end
        2'b01: begin
          hd_data <= tl_data;
          hd_id   <= tl_id;
          ob_cnt  <= ob_cnt - 2'd1;
        end
        2'b11: begin
          if (ob_cnt == 2'd1) begin
            hd_data <= sel_data;
            hd_id   <= sel_id;
          end else begin
            hd_data <= tl_data;
            hd_id   <= tl_id;
            tl_data <= sel_data;
            tl_id   <= sel_id;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ARB_REQ_CHK_EN
  // Sticky protocol error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err <= 1'b0;
    else if (bad) err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_arb_req_client.sv
// Bench for arb_req_client: directed test-plan cases plus a randomized arbiter,
// all checked against a queue-based model of the client FIFOs and output buffer.
module tb_arb_req_client;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [31:0] in_data;
  logic [3:0]  req;
  logic [3:0]  grant;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_id;
`ifdef ARB_REQ_CHK_EN
  logic        err;
`endif

  arb_req_client #(.N(4), .W(8), .DEPTH(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .req(req),
    .grant(grant),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_id(out_id)
`ifdef ARB_REQ_CHK_EN
    ,
    .err(err)
`endif
  );

  always #5 clk = ~clk;

  logic [7:0] fq [4][$];
  logic [9:0] ob [$];
  logic       m_err;
  logic [3:0] last_req;
  int         total;
  int         bad;

  logic [3:0] gs  [6] = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
  logic [1:0] ids [6] = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
  logic [7:0] ods [6] = '{8'h40, 8'h50, 8'h70, 8'h41, 8'h51, 8'h71};

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] mreq_f(input logic [3:0] g, input logic p);
    logic [3:0] r;
    int n;
    n = ob.size() + ((g != 0) ? 1 : 0) - (p ? 1 : 0);
    r = '0;
    for (int i = 0; i < 4; i++)
      r[i] = (fq[i].size() > (g[i] ? 1 : 0)) && (n <= 1);
    return r;
  endfunction

  function automatic logic [3:0] pick(input logic [3:0] r, input logic [3:0] cur,
                                      input bit idle_ok);
    int c[$];
    logic [3:0] one;
    one = 4'b0001;
    for (int i = 0; i < 4; i++)
      if (r[i] && !cur[i]) c.push_back(i);
    if (c.size() == 0) return 4'b0000;
    if (idle_ok && $urandom_range(3) == 0) return 4'b0000;
    return one << c[$urandom_range(c.size() - 1)];
  endfunction

  task automatic step(input logic [3:0] iv, input logic [31:0] dat,
                      input logic ordy, input logic [3:0] g);
    logic [3:0] ir;
    logic [3:0] er;
    logic       p;
    logic       badg;
    logic [7:0] v;
    logic [9:0] drop;
    @(negedge clk);
    in_valid  = iv;
    in_data   = dat;
    out_ready = ordy;
    grant     = g;
    #1;
    for (int i = 0; i < 4; i++) ir[i] = (fq[i].size() != 4);
    chk("in_ready", in_ready, ir);
    chk("out_valid", out_valid, ob.size() != 0);
    if (ob.size() != 0) begin
      chk("out_data", out_data, ob[0][7:0]);
      chk("out_id", out_id, ob[0][9:8]);
    end
    p  = (ob.size() != 0) && ordy;
    er = mreq_f(g, p);
    chk("req", req, er);
    last_req = er;
    badg = 1'b0;
`ifdef ARB_REQ_CHK_EN
    chk("err", err, m_err);
    if ($countones(g) > 1) badg = 1'b1;
    for (int i = 0; i < 4; i++)
      if (g[i] && fq[i].size() == 0) badg = 1'b1;
    if (g != 0 && ob.size() == 2 && !p) badg = 1'b1;
    if (badg) m_err = 1'b1;
`endif
    if (p) drop = ob.pop_front();
    if (!badg) begin
      for (int i = 0; i < 4; i++) begin
        if (g[i]) begin
          v = fq[i].pop_front();
          ob.push_back({2'(i), v});
        end
      end
    end
    for (int i = 0; i < 4; i++)
      if (iv[i] && ir[i]) fq[i].push_back(dat[i*8 +: 8]);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 4; i++) fq[i].delete();
    ob.delete();
    m_err = 1'b0;
  endtask

  initial begin
    logic [3:0] g;
    int gc;
    total     = 0;
    bad       = 0;
    m_err     = 1'b0;
    last_req  = '0;
    rst_n     = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
    grant     = '0;
    #3;
    chk("rst_in_ready", in_ready, 4'hF);
    chk("rst_req", req, 4'h0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_out_id", out_id, 2'd0);
`ifdef ARB_REQ_CHK_EN
    chk("rst_err", err, 1'b0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    step(4'b0100, 32'h00A50000, 1'b1, 4'b0000);
    step(4'b0000, 32'h0, 1'b1, 4'b0000);
    chk("t1_req", req, 4'b0100);
    step(4'b0000, 32'h0, 1'b1, 4'b0100);
    chk("t1_req_grant", req, 4'b0000);
    step(4'b0000, 32'h0, 1'b1, 4'b0000);
    chk("t1_valid", out_valid, 1'b1);
    chk("t1_data", out_data, 8'hA5);
    chk("t1_id", out_id, 2'd2);

    for (int k = 0; k < 4; k++)
      step(4'b0001, 32'h10 + k, 1'b1, 4'b0000);
    for (int j = 0; j < 8; j++) begin
      step(4'b0000, 32'h0, 1'b1, (j % 2 == 0) ? 4'b0001 : 4'b0000);
      if (j == 0) chk("t2_full", in_ready[0], 1'b0);
      if (j == 1) chk("t2_ready_back", in_ready[0], 1'b1);
      if (j % 2 == 1) chk("t2_order", out_data, 8'h10 + 8'(j / 2));
    end

    for (int k = 0; k < 2; k++)
      step(4'b1011, {8'h70 + 8'(k), 8'h00, 8'h50 + 8'(k), 8'h40 + 8'(k)},
           1'b1, 4'b0000);
    for (int j = 0; j < 7; j++) begin
      step(4'b0000, 32'h0, 1'b1, (j < 6) ? gs[j] : 4'b0000);
      if (j > 0) begin
        chk("t3_valid", out_valid, 1'b1);
        chk("t3_id", out_id, ids[j-1]);
        chk("t3_data", out_data, ods[j-1]);
      end
    end

    for (int k = 0; k < 3; k++)
      step(4'b0111, $urandom, 1'b0, 4'b0000);
    g  = pick(last_req, 4'b0000, 1'b0);
    gc = 0;
    for (int j = 0; j < 6; j++) begin
      step(4'b0000, 32'h0, 1'b0, g);
      if (g != 0) gc++;
      g = pick(last_req, g, 1'b0);
    end
    chk("t4_grants", gc, 2);
    chk("t4_req_off", req, 4'b0000);
    chk("t4_valid", out_valid, 1'b1);
    step(4'b0000, 32'h0, 1'b1, g);
    chk("t4_resume", req != 4'b0000, 1'b1);
    g = pick(last_req, g, 1'b1);
    for (int j = 0; j < 25; j++) begin
      step(4'b0000, 32'h0, 1'b1, g);
      g = pick(last_req, g, 1'b1);
    end

    for (int k = 0; k < 2; k++)
      step(4'b1111, $urandom, 1'b0, g);
    g = pick(last_req, 4'b0000, 1'b0);
    for (int j = 0; j < 4; j++) begin
      step(4'b0000, 32'h0, 1'b0, g);
      g = pick(last_req, g, 1'b0);
    end
    #2;
    rst_n    = 1'b0;
    in_valid = '0;
    grant    = '0;
    #1;
    chk("t5_in_ready", in_ready, 4'hF);
    chk("t5_req", req, 4'h0);
    chk("t5_valid", out_valid, 1'b0);
    chk("t5_data", out_data, 8'h00);
    chk("t5_id", out_id, 2'd0);
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 3; j++)
      step(4'b0000, 32'h0, 1'b1, 4'b0000);
    chk("t5_after", in_ready, 4'hF);

    g = 4'b0000;
    for (int j = 0; j < 2000; j++) begin
      step(4'($urandom), $urandom, ($urandom_range(3) != 0), g);
      g = pick(last_req, g, 1'b1);
    end
    for (int j = 0; j < 30; j++) begin
      step(4'b0000, 32'h0, 1'b1, g);
      g = pick(last_req, g, 1'b1);
    end

`ifdef ARB_REQ_CHK_EN
    step(4'b0011, 32'h0000_6160, 1'b1, 4'b0000);
    step(4'b0001, 32'h0000_0062, 1'b1, 4'b0000);
    step(4'b0000, 32'h0, 1'b1, 4'b0011);
    step(4'b0000, 32'h0, 1'b1, 4'b0000);
    chk("t6_err_multi", err, 1'b1);
    chk("t6_no_beat", out_valid, 1'b0);
    step(4'b0000, 32'h0, 1'b1, 4'b0100);
    step(4'b0000, 32'h0, 1'b1, 4'b0001);
    step(4'b0000, 32'h0, 1'b1, 4'b0000);
    chk("t6_err_sticky", err, 1'b1);
    chk("t6_good_beat", out_data, 8'h60);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
